// File: rtl/booth_accumulator.sv
// Sequential radix-2 Booth accumulator: adds or subtracts one shifted, sign-extended
// multiplicand per cycle from the encoder's x/z digit flags, with a start/busy/done handshake.
module booth_accumulator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mr,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     z,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    pp_c;

  // Partial product for the current digit position
  assign pp_c = {{WIDTH{mr_q[WIDTH-1]}}, mr_q} << cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mr_q    <= '0;
      x_q     <= '0;
      z_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mr_q    <= mr_d;
      x_q     <= x_d;
      z_q     <= z_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mr_d    = mr_q;
    x_d     = x_q;
    z_d     = z_q;
    acc_d   = acc_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mr_d    = mr;
          x_d     = x;
          z_d     = z;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // z gates the digit, so an x flag without z contributes nothing
        if (z_q[cnt_q]) begin
          acc_d = x_q[cnt_q] ? (acc_q - pp_c) : (acc_q + pp_c);
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered flags track the state being entered
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule
